// File: rtl/draw_rect_char.sv
// draw_rect_char
// Video pipeline stage that overlays a 16x16-character text box (128 x 256 pixels)
// on the VGA stream. It converts the pixel position into a character-cell address
// for the character ROM and a glyph row for the font ROM. It then paints the
// returned 8-pixel glyph row in COLOR over the incoming background.
//
// Pipeline (T = cycle in which the inputs are sampled):
//   T+1 char_yx valid        (character ROM returns char_code at T+2)
//   T+2 char_line valid      ({char_code, char_line} addresses the font ROM)
//   T+3 char_pixels valid
//   T+4 all *_out valid, with the overlay applied to rgb_out
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   hcount_in/vcount_in pixel position (11 bits each)
//   hsync_in/vsync_in   sync strobes
//   hblnk_in/vblnk_in   blanking strobes
//   rgb_in              background colour {r,g,b}
//   char_pixels         font ROM row data, bit 7 = leftmost pixel
//   char_yx             {row, col} cell address to the character ROM
//   char_line           glyph row to the font ROM
//   *_out               timing signals delayed by 4 cycles, rgb_out overlaid
//
// There is no back-pressure; the pipeline advances every cycle.
module draw_rect_char #(
  parameter int          XPOS  = 100,
  parameter int          YPOS  = 100,
  parameter logic [11:0] COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [7:0]  char_pixels,
  output logic [7:0]  char_yx,
  output logic [3:0]  char_line,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [10:0] X_LO = 11'(XPOS);
  localparam logic [10:0] X_HI = 11'(XPOS + 127);
  localparam logic [10:0] Y_LO = 11'(YPOS);
  localparam logic [10:0] Y_HI = 11'(YPOS + 255);
  localparam int          TW   = 38;  // timing bundle width

  // Box membership uses plain compares so positions left of / above the box can
  // never alias into it through subtraction wrap-around.
  logic          w_in_rect;
  logic [6:0]    w_rel_x;
  logic [7:0]    w_rel_y;
  logic [TW-1:0] w_tim_in;
  logic [2:0]    w_bit;

  assign w_in_rect = (hcount_in >= X_LO) && (hcount_in <= X_HI) &&
                     (vcount_in >= Y_LO) && (vcount_in <= Y_HI) &&
                     !hblnk_in && !vblnk_in;

  // Only the low bits of the offsets matter, and modular subtraction of the
  // low bits gives the same result as a full-width subtraction.
  assign w_rel_x = hcount_in[6:0] - X_LO[6:0];
  assign w_rel_y = vcount_in[7:0] - Y_LO[7:0];

  // {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}
  assign w_tim_in = {hcount_in, vcount_in, hsync_in, vsync_in,
                     hblnk_in, vblnk_in, rgb_in};

  logic [7:0]    r_char_yx;
  logic [3:0]    r_char_line;
  logic          r_in_rect_d1, r_in_rect_d2, r_in_rect_d3;
  logic [2:0]    r_rel_x_d1, r_rel_x_d2, r_rel_x_d3;
  logic [3:0]    r_rel_y_d1;
  logic [TW-1:0] r_tim_d1, r_tim_d2, r_tim_d3;
  logic [25:0]   r_tim_out;
  logic [11:0]   r_rgb_out;

  // Pixel column inside the glyph row; bit 7 is the leftmost pixel.
  assign w_bit = 3'd7 - r_rel_x_d3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_char_yx    <= 8'h00;
      r_char_line  <= 4'h0;
      r_in_rect_d1 <= 1'b0;
      r_in_rect_d2 <= 1'b0;
      r_in_rect_d3 <= 1'b0;
      r_rel_x_d1   <= 3'd0;
      r_rel_x_d2   <= 3'd0;
      r_rel_x_d3   <= 3'd0;
      r_rel_y_d1   <= 4'h0;
      r_tim_d1     <= '0;
      r_tim_d2     <= '0;
      r_tim_d3     <= '0;
      r_tim_out    <= '0;
      r_rgb_out    <= 12'h000;
    end else begin
      // Stage 1: cell address to the character ROM.
      r_char_yx    <= w_in_rect ? {w_rel_y[7:4], w_rel_x[6:3]} : 8'h00;
      r_in_rect_d1 <= w_in_rect;
      r_rel_x_d1   <= w_rel_x[2:0];
      r_rel_y_d1   <= w_rel_y[3:0];
      r_tim_d1     <= w_tim_in;
      // Stage 2: glyph row, lined up with char_code coming back from the ROM.
      r_char_line  <= r_in_rect_d1 ? r_rel_y_d1 : 4'h0;
      r_in_rect_d2 <= r_in_rect_d1;
      r_rel_x_d2   <= r_rel_x_d1;
      r_tim_d2     <= r_tim_d1;
      // Stage 3: wait for the font ROM row.
      r_in_rect_d3 <= r_in_rect_d2;
      r_rel_x_d3   <= r_rel_x_d2;
      r_tim_d3     <= r_tim_d2;
      // Stage 4: overlay.
      r_tim_out    <= r_tim_d3[TW-1:12];
      r_rgb_out    <= (r_in_rect_d3 && char_pixels[w_bit]) ? COLOR
                                                           : r_tim_d3[11:0];
    end
  end

  assign char_yx    = r_char_yx;
  assign char_line  = r_char_line;
  assign hcount_out = r_tim_out[25:15];
  assign vcount_out = r_tim_out[14:4];
  assign hsync_out  = r_tim_out[3];
  assign vsync_out  = r_tim_out[2];
  assign hblnk_out  = r_tim_out[1];
  assign vblnk_out  = r_tim_out[0];
  assign rgb_out    = r_rgb_out;

endmodule
